// File: rtl/cs_win.sv
// Sliding-window averager: keeps the last WIN accepted samples and their
// running sum, then one cycle later produces
//    Y = (S + WIN * Xsel) >> SHIFT
// where Xsel is either the window average floor(S/WIN) or the largest
// window sample not exceeding that average.
//
//  state | meaning
//  FILL  | fewer than WIN samples accepted since reset/clear; no results
//  RUN   | window full; every accepted sample yields a result next edge
module cs_win #(
    parameter int DATA_W = 8,
    parameter int WIN    = 9,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] X,
    input  logic              mode,
    input  logic              clear,
    output logic              out_valid,
    output logic [OUT_W-1:0]  Y,
    output logic              full
);

    localparam int SUM_W = DATA_W + $clog2(WIN);
    // S + WIN*Xsel never exceeds 2*S because Xsel <= floor(S/WIN).
    localparam int MUL_W = SUM_W + 1;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN);

    typedef enum logic {FILL, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  win_q [WIN];
    logic [SUM_W-1:0]   sum_q;
    logic               pend_q, pend_d;
    logic               mode_q;

    logic [SUM_W-1:0]   avg;
    logic [DATA_W-1:0]  appr;
    logic [SUM_W-1:0]   sel;
    logic [MUL_W-1:0]   total;
    logic [OUT_W-1:0]   y_next;

    // State, fill count, pending-result flag and captured mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            count_q <= '0;
            pend_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            if (in_valid && !clear) begin
                mode_q <= mode;
            end
        end
    end

    // Next-state logic: clear always wins over an incoming sample
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = 1'b0;
        if (clear) begin
            state_d = FILL;
            count_d = '0;
        end else if (in_valid) begin
            case (state_q)
                FILL: begin
                    if (count_q == CNT_LAST) begin
                        state_d = RUN;
                        count_d = CNT_FULL;
                        pend_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    pend_d = 1'b1;
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    // Shift window and running sum; unfilled slots hold 0 so the sum stays exact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (in_valid) begin
            win_q[0] <= X;
            for (int i = 1; i < WIN; i++) win_q[i] <= win_q[i-1];
            sum_q <= sum_q + SUM_W'(X) - SUM_W'(win_q[WIN-1]);
        end
    end

    // Average, approximate average and scaled result from the registered window
    always_comb begin
        avg  = sum_q / SUM_W'(WIN);
        appr = '0;
        for (int i = 0; i < WIN; i++) begin
            if ((SUM_W'(win_q[i]) <= avg) && (win_q[i] >= appr)) begin
                appr = win_q[i];
            end
        end
        sel    = mode_q ? avg : SUM_W'(appr);
        total  = MUL_W'(sum_q) + MUL_W'(sel) * MUL_W'(WIN);
        y_next = OUT_W'(total >> SHIFT);
    end

    // Output register: Y holds its value whenever no result is produced
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            Y         <= '0;
        end else begin
            out_valid <= pend_q && !clear;
            if (pend_q && !clear) begin
                Y <= y_next;
            end
        end
    end

    assign full = (count_q == CNT_FULL);

endmodule

// File: tb/tb_cs_win.sv
// Bench for cs_win: a driver issues samples and pushes the expected result
// (from a queue-based window model) into a scoreboard; a monitor checks
// every cycle for correct results, absent pulses, held Y and full.
module tb_cs_win;

    localparam int DATA_W = 8;
    localparam int WIN    = 9;
    localparam int SHIFT  = 3;
    localparam int OUT_W  = 10;

    typedef struct {
        int due;
        int y;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] X = '0;
    logic              mode = 1'b0;
    logic              clear = 1'b0;
    logic              out_valid;
    logic [OUT_W-1:0]  Y;
    logic              full;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    bit   pend = 1'b0;
    bit   full_model = 1'b0;
    exp_t exp_q[$];
    int   mq[$];

    cs_win #(.DATA_W(DATA_W), .WIN(WIN), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .mode(mode),
        .clear(clear), .out_valid(out_valid), .Y(Y), .full(full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: average and approximate average straight from the window contents
    function automatic int model_y(input logic m);
        int s = 0;
        int avg;
        int appr = -1;
        int sel;
        foreach (mq[i]) s += mq[i];
        avg = s / WIN;
        foreach (mq[i]) if (mq[i] <= avg && mq[i] > appr) appr = mq[i];
        sel = m ? avg : appr;
        return ((s + WIN * sel) / (1 << SHIFT)) % (1 << OUT_W);
    endfunction

    task automatic drive(input logic v, input int x, input logic m, input logic c, input int want);
        exp_t e;
        @(posedge clk);
        #1;
        full_model = (mq.size() == WIN);
        in_valid = v;
        X        = DATA_W'(x);
        mode     = m;
        clear    = c;
        if (c) begin
            if (pend) void'(exp_q.pop_back());
            mq.delete();
            pend = 1'b0;
        end else if (v) begin
            if (mq.size() == WIN) void'(mq.pop_front());
            mq.push_back(x);
            if (mq.size() == WIN) begin
                e.due = cyc + 2;
                e.y   = (want >= 0) ? want : model_y(m);
                exp_q.push_back(e);
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
        end else begin
            pend = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic do_reset();
        idle(2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        clear = 1'b0;
        mq.delete();
        pend = 1'b0;
        full_model = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic rnd_samples(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, -1);
    endtask

    // Driver
    initial begin
        int n;
        int r;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // nine samples of 10
        for (int i = 0; i < WIN; i++) drive(1'b1, 10, 1'b0, 1'b0, (i == WIN - 1) ? 22 : -1);
        idle(2);
        // ramp 1..9 then 10
        drive(1'b1, 99, 1'b0, 1'b1, -1);
        for (int i = 1; i <= 9; i++) drive(1'b1, i, 1'b0, 1'b0, (i == 9) ? 11 : -1);
        drive(1'b1, 10, 1'b0, 1'b0, 13);
        idle(2);
        // eight zeros then 255, both modes
        drive(1'b0, 0, 1'b0, 1'b1, -1);
        for (int i = 0; i < 8; i++) drive(1'b1, 0, 1'b1, 1'b0, -1);
        drive(1'b1, 255, 1'b0, 1'b0, 31);
        idle(2);
        drive(1'b0, 0, 1'b0, 1'b1, -1);
        for (int i = 0; i < 8; i++) drive(1'b1, 0, 1'b0, 1'b0, -1);
        drive(1'b1, 255, 1'b1, 1'b0, 63);
        idle(2);
        // all-max window
        drive(1'b0, 0, 1'b0, 1'b1, -1);
        for (int i = 0; i < WIN; i++) drive(1'b1, 255, 1'b0, 1'b0, (i == WIN - 1) ? 573 : -1);
        // three-cycle gaps while running
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, -1);
            idle(3);
        end
        // interruption by reset after 12 samples
        rnd_samples(12);
        do_reset();
        rnd_samples(12);
        // interruption by clear with a sample present
        drive(1'b1, int'($urandom_range(0, 255)), 1'b0, 1'b1, -1);
        rnd_samples(12);
        // long random run
        n = 0;
        while (n < 2000) begin
            r = int'($urandom_range(0, 199));
            if (r < 3) begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0, 1'b1, -1);
            end else if (r == 3) begin
                do_reset();
            end else if (r < 40) begin
                idle(1);
            end else begin
                drive(1'b1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, -1);
                n++;
            end
        end
        idle(3);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   last_y = 0;
        while (!done) begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (out_valid !== 1'b0 || full !== 1'b0 || Y !== '0) begin
                    failures++;
                    $display("FAIL reset_state: out_valid=%0b full=%0b Y=%0d, required 0 0 0", out_valid, full, Y);
                end
                last_y = 0;
            end else begin
                checks++;
                if (full !== full_model) begin
                    failures++;
                    $display("FAIL full: got %0b, required %0b (cycle %0d)", full, full_model, cyc);
                end
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_result: Y=%0d never presented, due cycle %0d", e.y, e.due);
                end
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (out_valid !== 1'b1 || Y !== OUT_W'(e.y)) begin
                        failures++;
                        $display("FAIL result: out_valid=%0b Y=%0d, required 1 %0d (cycle %0d)", out_valid, Y, e.y, cyc);
                    end
                    last_y = e.y;
                end else begin
                    checks++;
                    if (out_valid !== 1'b0 || Y !== OUT_W'(last_y)) begin
                        failures++;
                        $display("FAIL idle_hold: out_valid=%0b Y=%0d, required 0 %0d (cycle %0d)", out_valid, Y, last_y, cyc);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
